regfile_sb: RTL and testbench

//  - 32 x XLEN integer register file for the rv64IM core: the write end of the wb-stage writeback interface.
//  - Serves the decode stage: two async read ports, plus a per-register scoreboard of in-flight writers for RAW stall detection.
//  - Exports a0 continuously to the wb stage for exit/trap reporting.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 122 ++++++++++++
 tb/tb_regfile_sb.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Writeback, decode read/issue and a0 export signals of the rv64IM register file.
// Suffixes are from the register file's point of view; the master side drives the *_i signals.
interface regfile_sb_if #(
    parameter int unsigned XLEN = 64
);
    logic            wen_i;
    logic [4:0]      rd_i;
    logic [XLEN-1:0] wdata_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic [XLEN-1:0] rdata1_o;
    logic [XLEN-1:0] rdata2_o;
    logic            issue_i;
    logic [4:0]      issue_rd_i;
    logic            flush_i;
    logic            busy1_o;
    logic            busy2_o;
    logic            sb_full_o;
    logic [XLEN-1:0] a0_o;

    modport master (
        output wen_i, rd_i, wdata_i, rs1_i, rs2_i, issue_i, issue_rd_i, flush_i,
        input  rdata1_o, rdata2_o, busy1_o, busy2_o, sb_full_o, a0_o
    );

    modport slave (
        input  wen_i, rd_i, wdata_i, rs1_i, rs2_i, issue_i, issue_rd_i, flush_i,
        output rdata1_o, rdata2_o, busy1_o, busy2_o, sb_full_o, a0_o
    );
endinterface

// File: rtl/regfile_sb.sv
// 32 x XLEN register file with per-register in-flight-writer scoreboard and a0 export.
// Define RF_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_sb #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 2
) (
    input logic        clock,
    input logic        reset,
    regfile_sb_if.slave rf
);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero = '0;

    logic [XLEN-1:0]  regs_q [32];
    logic [CNT_W-1:0] cnt_q  [32];
    logic [CNT_W-1:0] cnt_d  [32];

    logic wr_en;
    logic full;
    logic inc;
    logic dec;
    logic same_reg;
    logic hit1;
    logic hit2;

    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            busy1;
    logic            busy2;

    assign wr_en    = rf.wen_i && (rf.rd_i != 5'd0);
    assign full     = (cnt_q[rf.issue_rd_i] == CntMax) && (rf.issue_rd_i != 5'd0);
    assign inc      = rf.issue_i && (rf.issue_rd_i != 5'd0) && !full;
    assign dec      = wr_en && (cnt_q[rf.rd_i] != CntZero);
    assign same_reg = inc && dec && (rf.issue_rd_i == rf.rd_i);

    // Register array: x0 is never written, so it stays at its reset value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rf.rd_i] <= rf.wdata_i;
        end
    end

    // Flush wins over everything; an issue and a retire on the same register cancel.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (rf.flush_i) begin
            for (int i = 0; i < 32; i++) begin
                cnt_d[i] = CntZero;
            end
        end else if (!same_reg) begin
            if (inc) begin
                cnt_d[rf.issue_rd_i] = cnt_q[rf.issue_rd_i] + CntOne;
            end
            if (dec) begin
                cnt_d[rf.rd_i] = cnt_q[rf.rd_i] - CntOne;
            end
        end
        cnt_d[0] = CntZero;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= CntZero;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign hit1 = wr_en && (rf.rd_i == rf.rs1_i);
    assign hit2 = wr_en && (rf.rd_i == rf.rs2_i);

`ifdef RF_BYPASS_EN
    // A retiring last writer no longer blocks a reader that sees its data this cycle.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rf.rs1_i != 5'd0) begin
            rdata1 = hit1 ? rf.wdata_i : regs_q[rf.rs1_i];
        end
        if (rf.rs2_i != 5'd0) begin
            rdata2 = hit2 ? rf.wdata_i : regs_q[rf.rs2_i];
        end
        busy1 = (cnt_q[rf.rs1_i] != CntZero) && !(hit1 && (cnt_q[rf.rs1_i] == CntOne));
        busy2 = (cnt_q[rf.rs2_i] != CntZero) && !(hit2 && (cnt_q[rf.rs2_i] == CntOne));
    end
`else
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rf.rs1_i != 5'd0) begin
            rdata1 = regs_q[rf.rs1_i];
        end
        if (rf.rs2_i != 5'd0) begin
            rdata2 = regs_q[rf.rs2_i];
        end
        busy1 = (cnt_q[rf.rs1_i] != CntZero);
        busy2 = (cnt_q[rf.rs2_i] != CntZero);
    end

    logic unused_hit;
    assign unused_hit = hit1 ^ hit2;
`endif

    assign rf.rdata1_o  = rdata1;
    assign rf.rdata2_o  = rdata2;
    assign rf.busy1_o   = busy1;
    assign rf.busy2_o   = busy2;
    assign rf.sb_full_o = full;
    assign rf.a0_o      = regs_q[10];
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, corner sequences, random vs. reference model.
module tb_regfile_sb;
    localparam int XLEN  = 64;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_sb_if #(.XLEN(XLEN)) rf_if ();

    regfile_sb #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .rf    (rf_if)
    );

    logic [63:0] m_regs [32];
    int          m_cnt  [32];
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        issue;
        logic [4:0]  ird;
        logic        flush;
        logic [63:0] e_r1;
        logic [63:0] e_r2;
        logic        e_b1;
        logic        e_b2;
        logic        e_full;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rf_if.wen_i      = 1'b0;
        rf_if.rd_i       = 5'd0;
        rf_if.wdata_i    = 64'd0;
        rf_if.rs1_i      = 5'd0;
        rf_if.rs2_i      = 5'd0;
        rf_if.issue_i    = 1'b0;
        rf_if.issue_rd_i = 5'd0;
        rf_if.flush_i    = 1'b0;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_cnt[i]  = 0;
        end
    endfunction

    // Reference: register values plus a pending-writer tally per register.
    task automatic model_edge();
        bit full, inc, dec;
        int ird, rd;
        if (!reset) begin
            model_clear();
            return;
        end
        ird  = int'(rf_if.issue_rd_i);
        rd   = int'(rf_if.rd_i);
        full = (ird != 0) && (m_cnt[ird] == MAXC);
        inc  = rf_if.issue_i && (ird != 0) && !full;
        dec  = rf_if.wen_i && (rd != 0) && (m_cnt[rd] > 0);
        if (rf_if.flush_i) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else if (!(inc && dec && ird == rd)) begin
            if (inc) m_cnt[ird] = m_cnt[ird] + 1;
            if (dec) m_cnt[rd] = m_cnt[rd] - 1;
        end
        if (rf_if.wen_i && rd != 0) m_regs[rd] = rf_if.wdata_i;
    endtask

    function automatic bit wb_hits(input logic [4:0] rs);
        return rf_if.wen_i && (rf_if.rd_i != 5'd0) && (rf_if.rd_i == rs);
    endfunction

    function automatic logic [63:0] exp_rdata(input logic [4:0] rs);
        if (rs == 5'd0) return 64'd0;
`ifdef RF_BYPASS_EN
        if (wb_hits(rs)) return rf_if.wdata_i;
`endif
        return m_regs[rs];
    endfunction

    function automatic logic exp_busy(input logic [4:0] rs);
        if (m_cnt[rs] == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wb_hits(rs) && m_cnt[rs] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " rdata1"}, rf_if.rdata1_o, exp_rdata(rf_if.rs1_i));
        chk({tag, " rdata2"}, rf_if.rdata2_o, exp_rdata(rf_if.rs2_i));
        chk({tag, " busy1"}, 64'(rf_if.busy1_o), 64'(exp_busy(rf_if.rs1_i)));
        chk({tag, " busy2"}, 64'(rf_if.busy2_o), 64'(exp_busy(rf_if.rs2_i)));
        chk({tag, " sb_full"}, 64'(rf_if.sb_full_o),
            64'((rf_if.issue_rd_i != 5'd0) && (m_cnt[rf_if.issue_rd_i] == MAXC)));
        chk({tag, " a0"}, rf_if.a0_o, m_regs[10]);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        model_clear();
        idle_inputs();

        // Inputs, then expected comb outputs before the edge; state starts with x5=0xAA.
        tbl[0] = '{1'b1, 5'd1, 64'h11, 5'd5, 5'd2, 1'b1, 5'd2, 1'b0, 64'hAA, 64'h0,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 64'h0,  5'd1, 5'd2, 1'b1, 5'd2, 1'b0, 64'h11, 64'h0,  1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 5'd2, 64'h22, 5'd1, 5'd5, 1'b0, 5'd2, 1'b0, 64'h11, 64'hAA, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 64'h0,  5'd2, 5'd1, 1'b1, 5'd2, 1'b0, 64'h22, 64'h11, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 64'h0,  5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 64'h22, 64'h0,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 64'h0,  5'd2, 5'd3, 1'b1, 5'd2, 1'b0, 64'h22, 64'h0,  1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 5'd3, 64'h33, 5'd2, 5'd5, 1'b0, 5'd0, 1'b1, 64'h22, 64'hAA, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 64'h0,  5'd2, 5'd3, 1'b0, 5'd2, 1'b0, 64'h22, 64'h33, 1'b0, 1'b0, 1'b0};

        // T1: write held off by reset, lands on first edge after release
        rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd5; rf_if.wdata_i = 64'hAA; rf_if.rs1_i = 5'd5;
        tick();
        tick();
        chk("t1 rdata1 in reset", rf_if.rdata1_o, 64'h0);
        chk("t1 busy1 in reset", 64'(rf_if.busy1_o), 64'h0);
        chk("t1 a0 in reset", rf_if.a0_o, 64'h0);
        reset = 1'b1;
        tick();
        rf_if.wen_i = 1'b0;
        #1;
        chk("t1 rdata1 after release", rf_if.rdata1_o, 64'hAA);

        for (int i = 0; i < 8; i++) begin
            rf_if.wen_i      = tbl[i].wen;
            rf_if.rd_i       = tbl[i].rd;
            rf_if.wdata_i    = tbl[i].wdata;
            rf_if.rs1_i      = tbl[i].rs1;
            rf_if.rs2_i      = tbl[i].rs2;
            rf_if.issue_i    = tbl[i].issue;
            rf_if.issue_rd_i = tbl[i].ird;
            rf_if.flush_i    = tbl[i].flush;
            #1;
            chk($sformatf("tbl%0d rdata1", i), rf_if.rdata1_o, tbl[i].e_r1);
            chk($sformatf("tbl%0d rdata2", i), rf_if.rdata2_o, tbl[i].e_r2);
            chk($sformatf("tbl%0d busy1", i), 64'(rf_if.busy1_o), 64'(tbl[i].e_b1));
            chk($sformatf("tbl%0d busy2", i), 64'(rf_if.busy2_o), 64'(tbl[i].e_b2));
            chk($sformatf("tbl%0d sb_full", i), 64'(rf_if.sb_full_o), 64'(tbl[i].e_full));
            tick();
        end
        idle_inputs();

        // T2: x0 ignores writes and issues
        rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd0; rf_if.wdata_i = '1;
        rf_if.issue_i = 1'b1; rf_if.issue_rd_i = 5'd0;
        #1;
        chk("t2 sb_full x0", 64'(rf_if.sb_full_o), 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("t2 rdata1 x0", rf_if.rdata1_o, 64'h0);
        chk("t2 busy1 x0", 64'(rf_if.busy1_o), 64'h0);

        // T3: same-cycle read of a register being written
        rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd7; rf_if.wdata_i = 64'h1;
        tick();
        rf_if.wdata_i = 64'h2; rf_if.rs1_i = 5'd7;
        #1;
`ifdef RF_BYPASS_EN
        chk("t3 rdata1 same cycle", rf_if.rdata1_o, 64'h2);
`else
        chk("t3 rdata1 same cycle", rf_if.rdata1_o, 64'h1);
`endif
        tick();
        rf_if.wen_i = 1'b0;
        #1;
        chk("t3 rdata1 next cycle", rf_if.rdata1_o, 64'h2);

        // T4: saturation at 3 pending writers, then drain
        idle_inputs();
        rf_if.rs1_i = 5'd3; rf_if.issue_i = 1'b1; rf_if.issue_rd_i = 5'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4 sb_full issue%0d", k), 64'(rf_if.sb_full_o), 64'h0);
            tick();
        end
        #1;
        chk("t4 sb_full at max", 64'(rf_if.sb_full_o), 64'h1);
        chk("t4 busy1 at max", 64'(rf_if.busy1_o), 64'h1);
        tick();
        rf_if.issue_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd3; rf_if.wdata_i = 64'(32'hC0 + k);
            tick();
            rf_if.wen_i = 1'b0;
            #1;
            chk($sformatf("t4 busy1 after wb%0d", k), 64'(rf_if.busy1_o), 64'(k < 2));
        end
        chk("t4 rdata1 final", rf_if.rdata1_o, 64'hC2);

        // T5: issue and retire on the same register cancel
        idle_inputs();
        rf_if.issue_i = 1'b1; rf_if.issue_rd_i = 5'd4;
        tick();
        rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd4; rf_if.wdata_i = 64'h44;
        tick();
        idle_inputs();
        rf_if.rs1_i = 5'd4;
        #1;
        chk("t5 busy1 kept", 64'(rf_if.busy1_o), 64'h1);
        chk("t5 rdata1 updated", rf_if.rdata1_o, 64'h44);
        rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd4; rf_if.wdata_i = 64'h45;
        tick();
        rf_if.wen_i = 1'b0;
        #1;
        chk("t5 busy1 drained", 64'(rf_if.busy1_o), 64'h0);

        // T6: flush with a0 write in the same cycle
        idle_inputs();
        rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd10; rf_if.wdata_i = 64'h1234;
        tick();
        idle_inputs();
        rf_if.issue_i = 1'b1; rf_if.issue_rd_i = 5'd9;
        tick();
        tick();
        idle_inputs();
        rf_if.rs1_i = 5'd9; rf_if.rs2_i = 5'd10;
        #1;
        chk("t6 busy1 before flush", 64'(rf_if.busy1_o), 64'h1);
        chk("t6 a0 before flush", rf_if.a0_o, 64'h1234);
        rf_if.flush_i = 1'b1; rf_if.wen_i = 1'b1; rf_if.rd_i = 5'd10; rf_if.wdata_i = 64'h0;
        tick();
        rf_if.flush_i = 1'b0; rf_if.wen_i = 1'b0;
        #1;
        chk("t6 busy1 after flush", 64'(rf_if.busy1_o), 64'h0);
        chk("t6 busy2 after flush", 64'(rf_if.busy2_o), 64'h0);
        chk("t6 a0 after flush", rf_if.a0_o, 64'h0);
        check_model("t6 model sync");

        // Random traffic on a narrow index range to force collisions; one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b0;
                model_clear();
                #1;
                check_model("rnd in reset");
                reset = 1'b1;
            end
            rf_if.wen_i      = 1'($urandom_range(0, 1));
            rf_if.rd_i       = 5'($urandom_range(0, 7));
            rf_if.wdata_i    = {$urandom, $urandom};
            rf_if.rs1_i      = 5'($urandom_range(0, 7));
            rf_if.rs2_i      = 5'($urandom_range(0, 7));
            rf_if.issue_i    = ($urandom_range(0, 9) < 6);
            rf_if.issue_rd_i = (i % 50 < 10) ? 5'd10 : 5'($urandom_range(0, 7));
            rf_if.flush_i    = ($urandom_range(0, 31) == 0);
            #1;
            check_model("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
